mlaccel_memctl: RTL and testbench
=================================

MLACCEL_MEMCTL -- requirements
Module: mlaccel_memctl

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 17, meaning the byte-address width of the attached mlaccel_memory.
REQ-002 SHALL have port clock, input, 1, the single clock for all logic.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset sampled on the rising edge of clock.
REQ-004 SHALL have cmd_valid/cmd_ready (in/out, 1 each), cmd_write (in, 1: 1=write, 0=read), cmd_addr (in, ADDR_BITS, start byte address) and cmd_len (in, ADDR_BITS: bytes for a write, words for a read).
REQ-005 SHALL have wr_valid (in, 1), wr_ready (out, 1) and wr_data (in, 8) as the byte-stream write input.
REQ-006 SHALL have rd_valid (out, 1), rd_ready (in, 1) and rd_data (out, 32) as the word-stream read output.
REQ-007 SHALL have mem_addr (out, ADDR_BITS), mem_wen (out, 1), mem_wdata (out, 8) and mem_rdata (in, 32), wired directly to mlaccel_memory addr/wen/wdata/rdata.
REQ-008 SHALL have busy, out, 1, high whenever the state is not IDLE.

Function
REQ-009 SHALL implement states IDLE, WRITE, READ and DRAIN.
REQ-010 SHALL drive cmd_ready=1 only in IDLE; a command is accepted on any cycle with cmd_valid&&cmd_ready.
REQ-011 SHALL, on a command with cmd_len=0, stay in IDLE without any memory access.
REQ-012 SHALL, on a write command, enter WRITE next cycle with address=cmd_addr and count=cmd_len.
REQ-013 SHALL drive wr_ready=1 only in WRITE; a byte transfers on each wr_valid&&wr_ready, at most one byte per cycle.
REQ-014 SHALL register each accepted byte: on the next cycle mem_wen=1, mem_addr=current address, mem_wdata=byte; on cycles without a transfer mem_wen=0.
REQ-015 SHALL increment the write address by 1 per byte, wrapping from 2^ADDR_BITS-1 to 0.
REQ-016 SHALL return from WRITE to IDLE on the cycle after the last byte is accepted, so cmd_ready is high in the same cycle as the final mem_wen pulse.
REQ-017 SHALL, on a read command, force the address to cmd_addr with bits [1:0] cleared and enter READ with count=cmd_len.
REQ-018 SHALL treat mem_rdata as valid exactly one cycle after mem_addr is presented with mem_wen=0.
REQ-019 SHALL issue a read address only when the number of buffered words plus reads in flight is less than 2, giving at most one issue per cycle.
REQ-020 SHALL increment the read address by 4 per issue, wrapping modulo 2^ADDR_BITS.
REQ-021 SHALL buffer returned words in a 2-entry FIFO; rd_valid=1 iff the FIFO is non-empty, and rd_data is the head entry.
REQ-022 SHALL transfer a word on each rd_valid&&rd_ready; the FIFO SHALL support a simultaneous push and pop in one cycle.
REQ-023 SHALL sustain one word per cycle with rd_ready held high, with first rd_valid 2 cycles after command acceptance.
REQ-024 SHALL move from READ to DRAIN after the last issue, and from DRAIN to IDLE on the cycle after the final word transfers.
REQ-025 SHALL hold rd_data stable while rd_valid=1 and rd_ready=0.

Reset
REQ-026 SHALL, while reset=1, force state=IDLE, busy=0, cmd_ready=0, wr_ready=0, rd_valid=0, mem_wen=0, mem_addr=0, mem_wdata=0, and an empty FIFO.
REQ-027 SHALL, on reset asserted mid-operation, abort the command, discard in-flight and buffered words, and not write any further byte.
REQ-028 SHALL assert cmd_ready=1 on the first cycle after reset deasserts.

Structure
REQ-029 SHALL take ADDR_BITS and the state enumeration from shared package mlaccel_pkg.
REQ-030 SHALL implement the 2-entry read FIFO as sub-module mlaccel_skidbuf (32-bit, 2 entries, valid/ready on both sides).

Verification
REQ-031 SHALL cover: write addr=0x00010, len=4, bytes 0xA0..0xA3 back-to-back -> mem_wen pulses 4 consecutive cycles at addr 0x10..0x13, then cmd_ready=1.
REQ-032 SHALL cover: read addr=0x00013, len=3, rd_ready=1 -> mem_addr 0x10,0x14,0x18; rd_valid on 3 consecutive cycles starting 2 cycles after acceptance.
REQ-033 SHALL cover: read len=4 with rd_ready=0 for 5 cycles, then 1 -> exactly 2 reads issued while stalled, rd_data stable, all 4 words delivered in order.
REQ-034 SHALL cover: write addr=0x1FFFE, len=3 -> mem_addr 0x1FFFE, 0x1FFFF, 0x00000.
REQ-035 SHALL cover: reset pulse after 2 of 8 bytes are written -> no further mem_wen, all outputs at reset values, next command accepted normally.
REQ-036 SHALL cover: cmd_len=0 for both write and read -> busy stays 0 and mem_wen stays 0.

Source files
------------

// File: rtl/mlaccel_pkg.sv
// Shared definitions for the mlaccel memory controller: default address width
// and the controller state enumeration.
package mlaccel_pkg;

  localparam int unsigned ADDR_BITS = 17;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN
  } memctl_state_e;

endpackage

// File: rtl/mlaccel_skidbuf.sv
// Two-entry valid/ready FIFO. The head entry is held stable until it is
// popped, and a push and a pop may happen in the same cycle.
module mlaccel_skidbuf #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_rptr;
  logic             r_wptr;
  logic [1:0]       r_count;
  logic             w_push;
  logic             w_pop;

  assign o_ready = (r_count != 2'd2);
  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_mem[r_rptr];
  assign w_push  = i_valid && o_ready;
  assign w_pop   = o_valid && i_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rptr  <= 1'b0;
      r_wptr  <= 1'b0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/mlaccel_memctl.sv
// mlaccel_memctl: bridges a byte-stream write port and a word-stream read port
// onto mlaccel_memory (byte writes, 32-bit reads returned one cycle later).
module mlaccel_memctl #(
  parameter int unsigned ADDR_BITS = mlaccel_pkg::ADDR_BITS
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [ADDR_BITS-1:0] cmd_addr,
  input  logic [ADDR_BITS-1:0] cmd_len,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [7:0]           wr_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [31:0]          rd_data,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_wen,
  output logic [7:0]           mem_wdata,
  input  logic [31:0]          mem_rdata,
  output logic                 busy
);

  import mlaccel_pkg::*;

  memctl_state_e        r_state;
  memctl_state_e        w_next;
  logic [ADDR_BITS-1:0] r_addr;
  logic [ADDR_BITS-1:0] r_count;
  logic [ADDR_BITS-1:0] r_wr_addr;
  logic [7:0]           r_wdata;
  logic                 r_mem_wen;
  logic                 r_inflight;
  logic                 w_cmd_fire;
  logic                 w_wr_fire;
  logic                 w_pop;
  logic                 w_issue;
  logic                 w_fifo_valid;
  logic                 w_fifo_in_ready;
  logic [31:0]          w_fifo_data;
  logic [2:0]           w_occupancy;

  assign cmd_ready = !reset && (r_state == IDLE);
  assign wr_ready  = !reset && (r_state == WRITE);
  assign busy      = !reset && (r_state != IDLE);
  assign rd_valid  = !reset && w_fifo_valid;
  assign rd_data   = w_fifo_data;
  assign mem_wen   = !reset && r_mem_wen;
  assign mem_wdata = reset ? '0 : r_wdata;
  assign mem_addr  = reset ? '0 : (r_mem_wen ? r_wr_addr : r_addr);

  assign w_cmd_fire = cmd_valid && cmd_ready;
  assign w_wr_fire  = wr_valid && wr_ready;
  assign w_pop      = rd_valid && rd_ready;

  // Words that will still occupy the FIFO after this cycle's pop: buffered
  // (full = !in_ready) plus the one returning from memory; a pop this cycle
  // frees a slot so streaming with rd_ready high issues every cycle.
  assign w_occupancy = {2'b00, w_fifo_valid} + {2'b00, !w_fifo_in_ready}
                     + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue = (r_state == READ) && (w_occupancy < 3'd2);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_cmd_fire && (cmd_len != '0)) w_next = cmd_write ? WRITE : READ;
      end
      WRITE: begin
        if (w_wr_fire && (r_count == ADDR_BITS'(1))) w_next = IDLE;
      end
      READ: begin
        if (w_issue && (r_count == ADDR_BITS'(1))) w_next = DRAIN;
      end
      DRAIN: begin
        if (!r_inflight && !w_fifo_valid) w_next = IDLE;
        else if (!r_inflight && w_fifo_in_ready && w_pop) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_count    <= '0;
      r_wr_addr  <= '0;
      r_wdata    <= '0;
      r_mem_wen  <= 1'b0;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_mem_wen  <= w_wr_fire;
      r_inflight <= w_issue;
      if (w_cmd_fire) begin
        r_addr  <= cmd_write ? cmd_addr : {cmd_addr[ADDR_BITS-1:2], 2'b00};
        r_count <= cmd_len;
      end else if (w_wr_fire) begin
        r_wr_addr <= r_addr;
        r_wdata   <= wr_data;
        r_addr    <= r_addr + ADDR_BITS'(1);
        r_count   <= r_count - ADDR_BITS'(1);
      end else if (w_issue) begin
        r_addr  <= r_addr + ADDR_BITS'(4);
        r_count <= r_count - ADDR_BITS'(1);
      end
    end
  end

  mlaccel_skidbuf #(
    .WIDTH(32)
  ) u_rdbuf (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_valid (r_inflight),
    .o_ready (w_fifo_in_ready),
    .i_data  (mem_rdata),
    .o_valid (w_fifo_valid),
    .i_ready (w_pop),
    .o_data  (w_fifo_data)
  );

endmodule

// File: tb/tb_mlaccel_memctl.sv
// Directed bench for mlaccel_memctl with a byte-array memory, a reference
// memory image and queues of required write pulses and read words.
module tb_mlaccel_memctl;

  localparam int unsigned AB  = 17;
  localparam int unsigned MSZ = 1 << AB;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AB-1:0] cmd_addr = '0;
  logic [AB-1:0] cmd_len = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [7:0]    wr_data = '0;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [31:0]   rd_data;
  logic [AB-1:0] mem_addr;
  logic          mem_wen;
  logic [7:0]    mem_wdata;
  logic [31:0]   mem_rdata = '0;
  logic          busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0]     mem     [MSZ];
  logic [7:0]     ref_mem [MSZ];
  logic [AB+7:0]  exp_wr [$];
  logic [31:0]    exp_rd [$];
  logic [AB-1:0]  wen_log [$];
  int             wen_cyc [$];
  int             rdv_cyc [$];

  mlaccel_memctl #(.ADDR_BITS(AB)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Stand-in for mlaccel_memory: byte write, little-endian word read one cycle later.
  always @(posedge clock) begin
    if (mem_wen) mem[mem_addr] <= mem_wdata;
    mem_rdata <= {mem[{mem_addr[AB-1:2], 2'd3}], mem[{mem_addr[AB-1:2], 2'd2}],
                  mem[{mem_addr[AB-1:2], 2'd1}], mem[{mem_addr[AB-1:2], 2'd0}]};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: condition not reached, required within bound (cycle %0d)", name, cyc);
  endtask

  // Per-cycle compare against the queues built from the commands and bytes sent.
  logic          p_valid = 1'b0;
  logic          p_ready = 1'b0;
  logic [31:0]   p_data  = '0;
  logic [AB+7:0] e_wr;
  always @(negedge clock) begin
    if (!reset) begin
      chk("busy_is_not_idle", 32'(busy), 32'(!cmd_ready));
      if (mem_wen) begin
        wen_log.push_back(mem_addr);
        wen_cyc.push_back(cyc);
        if (exp_wr.size() == 0) begin
          fail_now("unexpected_mem_wen");
        end else begin
          e_wr = exp_wr.pop_front();
          chk("mem_addr_on_write", 32'(mem_addr), 32'(e_wr[AB+7:8]));
          chk("mem_wdata", 32'(mem_wdata), 32'(e_wr[7:0]));
        end
      end
      if (rd_valid) begin
        rdv_cyc.push_back(cyc);
        if (p_valid && !p_ready) chk("rd_data_hold", rd_data, p_data);
        if (rd_ready) begin
          if (exp_rd.size() == 0) fail_now("unexpected_rd_word");
          else chk("rd_word", rd_data, exp_rd.pop_front());
        end
      end
    end
    p_valid <= rd_valid && !reset;
    p_ready <= rd_ready;
    p_data  <= rd_data;
  end

  task automatic send_cmd(input logic w, input logic [AB-1:0] a, input logic [AB-1:0] l);
    int unsigned t;
    int unsigned base;
    t = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
    @(negedge clock);
    while (!cmd_ready && t < 100) begin @(negedge clock); t++; end
    if (!cmd_ready) fail_now("cmd_accept_timeout");
    else if (!w) begin
      for (int unsigned i = 0; i < 32'(l); i++) begin
        base = ((32'(a) & ~32'd3) + 4 * i) % MSZ;
        exp_rd.push_back({ref_mem[base + 3], ref_mem[base + 2], ref_mem[base + 1], ref_mem[base]});
      end
    end
    @(posedge clock); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_bytes(input logic [AB-1:0] a, input int n, input logic [7:0] first,
                            input logic [7:0] step);
    int unsigned t;
    int unsigned wa;
    logic [7:0]  d;
    for (int i = 0; i < n; i++) begin
      t = 0;
      d = first + step * 8'(i);
      wr_valid = 1'b1; wr_data = d;
      @(negedge clock);
      while (!wr_ready && t < 100) begin @(negedge clock); t++; end
      if (!wr_ready) fail_now("wr_accept_timeout");
      else begin
        wa = (32'(a) + 32'(i)) % MSZ;
        exp_wr.push_back({AB'(wa), d});
        ref_mem[wa] = d;
      end
      @(posedge clock); #1;
    end
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int unsigned t;
    t = 0;
    @(negedge clock);
    while ((busy || exp_rd.size() != 0 || exp_wr.size() != 0) && t < 200) begin
      @(negedge clock); t++;
    end
    if (t >= 200) fail_now(name);
    @(posedge clock); #1;
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_busy"},      32'(busy),      32'd0);
    chk({name, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
    chk({name, "_wr_ready"},  32'(wr_ready),  32'd0);
    chk({name, "_rd_valid"},  32'(rd_valid),  32'd0);
    chk({name, "_mem_wen"},   32'(mem_wen),   32'd0);
    chk({name, "_mem_addr"},  32'(mem_addr),  32'd0);
    chk({name, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
  endtask

  logic [AB-1:0] rd2_addr [3] = '{17'h00010, 17'h00014, 17'h00018};

  initial begin
    for (int unsigned i = 0; i < MSZ; i++) begin
      mem[i]     = 8'(i) ^ 8'h5A;
      ref_mem[i] = 8'(i) ^ 8'h5A;
    end

    // Power-on reset
    repeat (3) begin
      @(negedge clock);
      chk_reset_outputs("por");
    end
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("por_cmd_ready_after_release", 32'(cmd_ready), 32'd1);
    @(posedge clock); #1;

    // Four back-to-back bytes at 0x10
    wen_cyc.delete();
    send_cmd(1'b1, 17'h00010, 17'd4);
    send_bytes(17'h00010, 4, 8'hA0, 8'h01);
    @(negedge clock);
    chk("wr4_last_wen", 32'(mem_wen), 32'd1);
    chk("wr4_last_addr", 32'(mem_addr), 32'h13);
    chk("wr4_last_data", 32'(mem_wdata), 32'hA3);
    chk("wr4_cmd_ready_with_last_wen", 32'(cmd_ready), 32'd1);
    wait_idle("wr4_idle_timeout");
    chk("wr4_pulse_count", 32'(wen_cyc.size()), 32'd4);
    if (wen_cyc.size() == 4) chk("wr4_pulses_consecutive", 32'(wen_cyc[3] - wen_cyc[0]), 32'd3);

    // Streaming read of 3 words from unaligned 0x13
    rd_ready = 1'b1;
    send_cmd(1'b0, 17'h00013, 17'd3);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      if (k <= 3) chk("rd3_issue_addr", 32'(mem_addr), 32'(rd2_addr[k-1]));
      if (k <= 2) chk("rd3_no_early_valid", 32'(rd_valid), 32'd0);
      if (k >= 3 && k <= 5) chk("rd3_valid_run", 32'(rd_valid), 32'd1);
      if (k == 3) chk("rd3_word0", rd_data, 32'hA3A2A1A0);
      if (k == 4) chk("rd3_word1", rd_data, 32'h4D4C4F4E);
      if (k == 5) chk("rd3_word2", rd_data, 32'h41404342);
      if (k == 6) begin
        chk("rd3_valid_done", 32'(rd_valid), 32'd0);
        chk("rd3_back_to_idle", 32'(cmd_ready), 32'd1);
      end
    end
    @(posedge clock); #1;

    // Read of 4 words with rd_ready held low for 5 cycles
    rd_ready = 1'b0;
    send_cmd(1'b0, 17'h00100, 17'd4);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      if (k >= 3) begin
        chk("stall_two_issues_only", 32'(mem_addr), 32'h108);
        chk("stall_rd_valid", 32'(rd_valid), 32'd1);
        chk("stall_head_word", rd_data, 32'h59585B5A);
      end
    end
    @(posedge clock); #1;
    rd_ready = 1'b1;
    wait_idle("stall_drain_timeout");
    chk("stall_all_words_delivered", 32'(exp_rd.size()), 32'd0);

    // Write wrapping past the top of the address space
    wen_log.delete();
    send_cmd(1'b1, 17'h1FFFE, 17'd3);
    send_bytes(17'h1FFFE, 3, 8'h11, 8'h11);
    wait_idle("wrap_idle_timeout");
    chk("wrap_pulse_count", 32'(wen_log.size()), 32'd3);
    if (wen_log.size() == 3) begin
      chk("wrap_addr0", 32'(wen_log[0]), 32'h1FFFE);
      chk("wrap_addr1", 32'(wen_log[1]), 32'h1FFFF);
      chk("wrap_addr2", 32'(wen_log[2]), 32'h00000);
    end

    // Reset pulse after 2 of 8 bytes
    send_cmd(1'b1, 17'h00200, 17'd8);
    send_bytes(17'h00200, 2, 8'h50, 8'h01);
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    chk_reset_outputs("midreset");
    exp_wr.delete();
    @(posedge clock); #1;
    @(negedge clock);
    chk_reset_outputs("midreset_held");
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("midreset_cmd_ready_after_release", 32'(cmd_ready), 32'd1);
    repeat (3) begin
      @(negedge clock);
      chk("midreset_no_more_wen", 32'(mem_wen), 32'd0);
    end
    @(posedge clock); #1;
    send_cmd(1'b1, 17'h00300, 17'd2);
    send_bytes(17'h00300, 2, 8'hC0, 8'h01);
    wait_idle("post_reset_write_timeout");
    send_cmd(1'b0, 17'h00200, 17'd2);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      if (k == 3) chk("midreset_readback0", rd_data, 32'h59585150);
      if (k == 4) chk("midreset_readback1", rd_data, 32'h5D5C5F5E);
    end
    wait_idle("post_reset_read_timeout");

    // Zero-length commands
    send_cmd(1'b1, 17'h00040, 17'd0);
    repeat (4) begin
      @(negedge clock);
      chk("len0_write_busy", 32'(busy), 32'd0);
      chk("len0_write_wen", 32'(mem_wen), 32'd0);
    end
    @(posedge clock); #1;
    send_cmd(1'b0, 17'h00040, 17'd0);
    repeat (4) begin
      @(negedge clock);
      chk("len0_read_busy", 32'(busy), 32'd0);
      chk("len0_read_wen", 32'(mem_wen), 32'd0);
      chk("len0_read_rd_valid", 32'(rd_valid), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule
